// File: rtl/wb_arbiter.sv
// wb_arbiter: three per-producer result FIFOs drained round-robin onto one registered writeback bus.
module wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int TAG_W  = 3,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_in,
   input  logic              alu0_en_in,
   input  logic [DATA_W-1:0] alu0_data_in,
   input  logic [ADDR_W-1:0] alu0_addrw_in,
   input  logic [TAG_W-1:0]  alu0_tagw_in,
   output logic              alu0_full_out,
   input  logic              alu1_en_in,
   input  logic [DATA_W-1:0] alu1_data_in,
   input  logic [ADDR_W-1:0] alu1_addrw_in,
   input  logic [TAG_W-1:0]  alu1_tagw_in,
   output logic              alu1_full_out,
   input  logic              ls_en_in,
   input  logic [DATA_W-1:0] ls_data_in,
   input  logic [ADDR_W-1:0] ls_addrw_in,
   input  logic [TAG_W-1:0]  ls_tagw_in,
   output logic              ls_full_out,
   output logic              wb_en_out,
   output logic [DATA_W-1:0] wb_data_out,
   output logic [ADDR_W-1:0] wb_addr_out,
   output logic [TAG_W-1:0]  wb_tag_out,
   output logic [1:0]        wb_src_out
);
   localparam int EW = DATA_W + ADDR_W + TAG_W;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [EW-1:0] mem [3][DEPTH];
   logic [EW-1:0] din [3];
   logic [CW-1:0] count [3];
   logic [PW-1:0] wptr [3];
   logic [PW-1:0] rptr [3];
   logic [2:0]    en, full, nonempty, push, pop;
   logic [1:0]    rr_ptr, gnt, c1, c2;
   logic          gnt_v;
   logic [EW-1:0] head;

   function automatic logic [1:0] nxt(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   assign en = {ls_en_in, alu1_en_in, alu0_en_in};
   assign din[0] = {alu0_data_in, alu0_addrw_in, alu0_tagw_in};
   assign din[1] = {alu1_data_in, alu1_addrw_in, alu1_tagw_in};
   assign din[2] = {ls_data_in, ls_addrw_in, ls_tagw_in};
   assign {ls_full_out, alu1_full_out, alu0_full_out} = full;

   // Arbitration looks only at registered counts, so a push never reaches the bus in its own cycle.
   always_comb begin
      for (int j = 0; j < 3; j++) begin
         full[j] = count[j] == FULL_CNT;
         nonempty[j] = count[j] != '0;
      end
      c1 = nxt(rr_ptr);
      c2 = nxt(c1);
      gnt = nonempty[rr_ptr] ? rr_ptr : nonempty[c1] ? c1 : c2;
      gnt_v = |nonempty;
      push = en & ~full & {3{~flush_in}};
      pop = (gnt_v && !flush_in) ? 3'b001 << gnt : 3'b000;
      head = mem[gnt][rptr[gnt]];
   end

   always_ff @(posedge clk)
      for (int j = 0; j < 3; j++)
         if (push[j]) mem[j][wptr[j]] <= din[j];

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int j = 0; j < 3; j++) begin
            count[j] <= '0;
            wptr[j] <= '0;
            rptr[j] <= '0;
         end
         rr_ptr <= '0;
         wb_en_out <= 1'b0;
         wb_data_out <= '0;
         wb_addr_out <= '0;
         wb_tag_out <= '0;
         wb_src_out <= '0;
      end else if (flush_in) begin
         for (int j = 0; j < 3; j++) begin
            count[j] <= '0;
            wptr[j] <= '0;
            rptr[j] <= '0;
         end
         wb_en_out <= 1'b0;
      end else begin
         for (int j = 0; j < 3; j++) begin
            if (push[j]) wptr[j] <= wptr[j] + PW'(1);
            if (pop[j]) rptr[j] <= rptr[j] + PW'(1);
            if (push[j] != pop[j]) count[j] <= push[j] ? count[j] + CW'(1) : count[j] - CW'(1);
         end
         wb_en_out <= gnt_v;
         if (gnt_v) begin
            {wb_data_out, wb_addr_out, wb_tag_out} <= head;
            wb_src_out <= gnt;
            rr_ptr <= nxt(gnt);
         end
      end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus with a queue scoreboard checked by an independent bus monitor.
module tb_wb_arbiter;
   logic clk = 0, rst, flush_in;
   logic alu0_en_in, alu1_en_in, ls_en_in;
   logic [31:0] alu0_data_in, alu1_data_in, ls_data_in;
   logic [4:0] alu0_addrw_in, alu1_addrw_in, ls_addrw_in;
   logic [2:0] alu0_tagw_in, alu1_tagw_in, ls_tagw_in;
   logic alu0_full_out, alu1_full_out, ls_full_out;
   logic wb_en_out;
   logic [31:0] wb_data_out;
   logic [4:0] wb_addr_out;
   logic [2:0] wb_tag_out;
   logic [1:0] wb_src_out;

   typedef struct packed {
      logic [1:0]  src;
      logic [31:0] data;
      logic [4:0]  addr;
      logic [2:0]  tag;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int checks = 0, fails = 0, drops = 0;

   wb_arbiter dut (
      .clk(clk), .rst(rst), .flush_in(flush_in),
      .alu0_en_in(alu0_en_in), .alu0_data_in(alu0_data_in), .alu0_addrw_in(alu0_addrw_in),
      .alu0_tagw_in(alu0_tagw_in), .alu0_full_out(alu0_full_out),
      .alu1_en_in(alu1_en_in), .alu1_data_in(alu1_data_in), .alu1_addrw_in(alu1_addrw_in),
      .alu1_tagw_in(alu1_tagw_in), .alu1_full_out(alu1_full_out),
      .ls_en_in(ls_en_in), .ls_data_in(ls_data_in), .ls_addrw_in(ls_addrw_in),
      .ls_tagw_in(ls_tagw_in), .ls_full_out(ls_full_out),
      .wb_en_out(wb_en_out), .wb_data_out(wb_data_out), .wb_addr_out(wb_addr_out),
      .wb_tag_out(wb_tag_out), .wb_src_out(wb_src_out)
   );

   always #5 clk = ~clk;

   // Pushes offered while the FIFO is full are dropped by the design; tally them.
   always @(posedge clk)
      if (!rst && !flush_in)
         drops += int'(alu0_en_in && alu0_full_out) + int'(alu1_en_in && alu1_full_out) +
                  int'(ls_en_in && ls_full_out);

   always @(negedge clk)
      if (!rst && wb_en_out) begin
         checks++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL wb_unexpected: got src=%0d data=%h, required no writeback", wb_src_out, wb_data_out);
         end else begin
            e = sb.pop_front();
            if ({wb_src_out, wb_data_out, wb_addr_out, wb_tag_out} !== e) begin
               fails++;
               $display("FAIL wb_payload: got src=%0d data=%h addr=%0d tag=%0d, required src=%0d data=%h addr=%0d tag=%0d",
                        wb_src_out, wb_data_out, wb_addr_out, wb_tag_out, e.src, e.data, e.addr, e.tag);
            end
         end
      end

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", n, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clr;
      {alu0_en_in, alu1_en_in, ls_en_in} = '0;
      {alu0_data_in, alu1_data_in, ls_data_in} = '0;
      {alu0_addrw_in, alu1_addrw_in, ls_addrw_in} = '0;
      {alu0_tagw_in, alu1_tagw_in, ls_tagw_in} = '0;
   endtask

   task automatic drive(input int s, input logic [31:0] d, input logic [4:0] a, input logic [2:0] t);
      if (s == 0) {alu0_en_in, alu0_data_in, alu0_addrw_in, alu0_tagw_in} = {1'b1, d, a, t};
      else if (s == 1) {alu1_en_in, alu1_data_in, alu1_addrw_in, alu1_tagw_in} = {1'b1, d, a, t};
      else {ls_en_in, ls_data_in, ls_addrw_in, ls_tagw_in} = {1'b1, d, a, t};
   endtask

   task automatic expect_wb(input logic [1:0] s, input logic [31:0] d, input logic [4:0] a, input logic [2:0] t);
      sb.push_back('{src: s, data: d, addr: a, tag: t});
   endtask

   task automatic reset_dut;
      rst = 1;
      tick;
      rst = 0;
      sb.delete();
   endtask

   initial begin
      rst = 1;
      flush_in = 0;
      clr;
      tick;
      tick;
      chk("rst_wb_en", wb_en_out, 0);
      chk("rst_wb_bus", {wb_data_out, wb_addr_out, wb_tag_out, wb_src_out}, 0);
      chk("rst_full", {ls_full_out, alu1_full_out, alu0_full_out}, 0);
      rst = 0;
      // alu0 reaches two entries, then an asynchronous reset lands mid-cycle
      drive(0, 32'h100, 1, 1); drive(1, 32'h200, 2, 2);
      expect_wb(0, 32'h100, 1, 1); expect_wb(1, 32'h200, 2, 2);
      tick; clr; drive(0, 32'h101, 1, 1);
      tick; drive(0, 32'h102, 1, 1);
      tick; clr;
      chk("a0_full_at_two", alu0_full_out, 1);
      @(negedge clk); #1;
      rst = 1; #1;
      chk("async_rst_wb_en", wb_en_out, 0);
      chk("async_rst_full", {ls_full_out, alu1_full_out, alu0_full_out}, 0);
      chk("pre_rst_drained", sb.size(), 0);
      tick; rst = 0;
      repeat (4) tick;
      chk("post_rst_idle", wb_en_out, 0);
      chk("post_rst_full", {ls_full_out, alu1_full_out, alu0_full_out}, 0);
      // two-cycle latency, no bypass
      drive(1, 32'hDEADBEEF, 5, 2); expect_wb(1, 32'hDEADBEEF, 5, 2);
      tick; clr;
      chk("no_bypass", wb_en_out, 0);
      tick;
      chk("lat_en", wb_en_out, 1);
      chk("lat_src", wb_src_out, 1);
      tick;
      chk("lat_done", wb_en_out, 0);
      chk("wb_hold", wb_data_out, 32'hDEADBEEF);
      // round-robin over a full backlog
      reset_dut;
      drive(0, 32'h10, 10, 1); drive(1, 32'h20, 11, 2); drive(2, 32'h30, 12, 3);
      expect_wb(0, 32'h10, 10, 1); expect_wb(1, 32'h20, 11, 2); expect_wb(2, 32'h30, 12, 3);
      expect_wb(0, 32'h11, 13, 4); expect_wb(1, 32'h21, 14, 5); expect_wb(2, 32'h31, 15, 6);
      tick;
      drive(0, 32'h11, 13, 4); drive(1, 32'h21, 14, 5); drive(2, 32'h31, 15, 6);
      tick; clr;
      chk("rr_first_wb", wb_en_out, 1);
      chk("rr_full_flags", {ls_full_out, alu1_full_out, alu0_full_out}, 3'b110);
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("rr_throughput", wb_en_out, 1);
      end
      tick;
      chk("rr_drained", wb_en_out, 0);
      // ls backpressure while alu0 streams
      drive(0, 32'h50, 1, 0); drive(2, 32'hA, 2, 0);
      expect_wb(0, 32'h50, 1, 0); expect_wb(2, 32'hA, 2, 0); expect_wb(0, 32'h51, 1, 1);
      expect_wb(2, 32'hB, 2, 1); expect_wb(0, 32'h52, 1, 2);
      tick;
      drive(0, 32'h51, 1, 1); drive(2, 32'hB, 2, 1);
      tick;
      chk("ls_full_at_two", ls_full_out, 1);
      drive(0, 32'h52, 1, 2); drive(2, 32'hC, 2, 2);
      tick; clr;
      chk("ls_full_after_pop", ls_full_out, 0);
      chk("a0_full_bp", alu0_full_out, 1);
      chk("drop_ls_c", drops, 1);
      repeat (4) tick;
      chk("bp_drained", wb_en_out, 0);
      // flush with rr_ptr parked on ls
      drive(0, 32'h60, 3, 0); drive(1, 32'h65, 4, 1); drive(2, 32'h70, 6, 2);
      expect_wb(1, 32'h65, 4, 1);
      tick; clr; drive(0, 32'h61, 3, 1);
      tick; clr;
      chk("a0_full_pre_flush", alu0_full_out, 1);
      flush_in = 1; drive(1, 32'h80, 7, 3);
      tick; flush_in = 0; clr;
      chk("flush_wb_en", wb_en_out, 0);
      chk("flush_full", {ls_full_out, alu1_full_out, alu0_full_out}, 0);
      repeat (3) tick;
      chk("flush_idle", wb_en_out, 0);
      drive(0, 32'h91, 8, 1); drive(1, 32'h92, 9, 2); drive(2, 32'h93, 10, 3);
      expect_wb(2, 32'h93, 10, 3); expect_wb(0, 32'h91, 8, 1); expect_wb(1, 32'h92, 9, 2);
      tick; clr;
      repeat (4) tick;
      // push into full alu0 in the same cycle it is popped
      reset_dut;
      drive(0, 32'hA0, 1, 1); drive(1, 32'hB0, 2, 2); drive(2, 32'hC0, 3, 3);
      expect_wb(0, 32'hA0, 1, 1); expect_wb(1, 32'hB0, 2, 2); expect_wb(2, 32'hC0, 3, 3);
      expect_wb(0, 32'hA1, 1, 4); expect_wb(0, 32'hA2, 1, 5);
      tick; clr; drive(0, 32'hA1, 1, 4);
      tick; drive(0, 32'hA2, 1, 5);
      tick; clr;
      chk("a0_full_c6", alu0_full_out, 1);
      tick;
      chk("a0_still_full", alu0_full_out, 1);
      drive(0, 32'hA4, 1, 6);
      tick; clr;
      chk("a0_count_one", alu0_full_out, 0);
      chk("drop_push_pop", drops, 2);
      repeat (4) tick;
      chk("final_idle", wb_en_out, 0);
      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
